vga_timer: RTL and testbench

VGA_TIMER -- requirements
Module: vga_timer

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_light_decode.sv | 38 +++
 rtl/vga_timer.sv | 71 +++++++
 tb/tb_vga_timer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA light display: colours, light columns and the light row.
// Latency: n/a (package only).
// Backpressure: none; this package holds only constants.
package vga_pkg;

  localparam int NUM_LIGHTS = 6;

  // 24-bit colours, packed as {R, G, B}
  localparam logic [23:0] BLACK      = 24'h00_00_00;
  localparam logic [23:0] ON         = 24'h00_FF_00;
  localparam logic [23:0] OFF        = 24'h40_40_40;
  localparam logic [23:0] BACKGROUND = 24'h00_00_80;
  localparam logic [23:0] BORDER     = 24'hFF_FF_FF;

  // First hcount of each light column, indexed by light number (L0..L5)
  localparam logic [9:0] COL_START [NUM_LIGHTS] = '{
    10'd664,  // L0
    10'd584,  // L1
    10'd504,  // L2
    10'd384,  // L3
    10'd304,  // L4
    10'd224   // L5
  };

  localparam logic [9:0] LIGHT_W = 10'd40;

  // Light row is the half-open range [ROW_START, ROW_END)
  localparam logic [9:0] ROW_START = 10'd229;
  localparam logic [9:0] ROW_END   = 10'd260;

endpackage

// File: rtl/vga_light_decode.sv
// Combinational decode of the beam position into "which light, if any" plus an edge flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle.
// Ports: hcount/vcount in; in_light, light_idx (0..5 = L0..L5) and edge_flag out.
//   edge_flag marks the outermost pixel ring of a light (first/last column or row).
module vga_light_decode
  import vga_pkg::*;
(
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic       in_light,
  output logic [2:0] light_idx,
  output logic       edge_flag
);

  logic in_row;
  logic row_edge;

  assign in_row   = (vcount >= ROW_START) && (vcount < ROW_END);
  assign row_edge = (vcount == ROW_START) || (vcount == ROW_END - 10'd1);

  // Columns never overlap, so at most one iteration can match.
  always_comb begin
    in_light  = 1'b0;
    light_idx = 3'd0;
    edge_flag = 1'b0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      if (in_row && (hcount >= COL_START[i]) && (hcount < COL_START[i] + LIGHT_W)) begin
        in_light  = 1'b1;
        light_idx = 3'(i);
        edge_flag = row_edge ||
                    (hcount == COL_START[i]) ||
                    (hcount == COL_START[i] + LIGHT_W - 10'd1);
      end
    end
  end

endmodule

// File: rtl/vga_timer.sv
// Pixel colour generator drawing six LED lights over a blue background.
// Latency: 1 clock from hcount/vcount/bright/LEDs to VGA_R/G/B.
// Backpressure: none; a new pixel is accepted and produced every clock.
// Ports: clk, rst_n (async, active low), bright, hcount, vcount, LEDs in;
//   VGA_R, VGA_G, VGA_B out (registered, cleared immediately on reset).
// Build option: define VGA_TIMER_LIGHT_BORDER_EN to outline each light in white.
module vga_timer
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bright,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [5:0] LEDs,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  logic        in_light;
  logic [2:0]  light_idx;
  logic        light_edge;
  logic        led_on;
  logic [23:0] rgb_nxt;
  logic [23:0] rgb_q;

  vga_light_decode u_decode (
    .hcount    (hcount),
    .vcount    (vcount),
    .in_light  (in_light),
    .light_idx (light_idx),
    .edge_flag (light_edge)
  );

`ifndef VGA_TIMER_LIGHT_BORDER_EN
  // The edge flag has no consumer when borders are disabled.
  logic unused_light_edge;
  assign unused_light_edge = light_edge;
`endif

  // Mask-and-reduce picks LEDs[light_idx] without an out-of-range index for idx 6/7.
  assign led_on = |(LEDs & (6'b000001 << light_idx));

  always_comb begin
    rgb_nxt = BACKGROUND;
    if (!bright) begin
      rgb_nxt = BLACK;
    end else if (in_light) begin
      rgb_nxt = led_on ? ON : OFF;
`ifdef VGA_TIMER_LIGHT_BORDER_EN
      if (light_edge) begin
        rgb_nxt = BORDER;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= BLACK;
    end else begin
      rgb_q <= rgb_nxt;
    end
  end

  assign VGA_R = rgb_q[23:16];
  assign VGA_G = rgb_q[15:8];
  assign VGA_B = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timer.sv
// Self-checking bench for vga_timer: directed cases plus randomized pixels against a reference model.
// Latency: checks each output one clock after its inputs were applied.
// Backpressure: none.
module tb_vga_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bright;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [5:0] LEDs;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bright (bright),
    .hcount (hcount),
    .vcount (vcount),
    .LEDs   (LEDs),
    .VGA_R  (VGA_R),
    .VGA_G  (VGA_G),
    .VGA_B  (VGA_B)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rgb_out();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h, expected %06h", tag, got, exp);
    end
  endtask

  // Reference model written from the display rules: light n occupies
  // columns [start_n, start_n+40) within rows [229, 260).
  function automatic logic [23:0] model(input bit b, input int h, input int v, input bit [5:0] leds);
    int starts [6] = '{664, 584, 504, 384, 304, 224};
    if (!b) return 24'h000000;
    if (v >= 229 && v < 260) begin
      for (int n = 0; n < 6; n++) begin
        if (h >= starts[n] && h < starts[n] + 40) begin
`ifdef VGA_TIMER_LIGHT_BORDER_EN
          if (h == starts[n] || h == starts[n] + 39 || v == 229 || v == 259) return 24'hFFFFFF;
`endif
          return leds[n] ? 24'h00FF00 : 24'h404040;
        end
      end
    end
    return 24'h000080;
  endfunction

  // Drive on the falling edge, check 1 time unit after the next rising edge.
  task automatic apply(input string tag, input bit b, input int h, input int v, input bit [5:0] leds);
    @(negedge clk);
    bright = b;
    hcount = 10'(h);
    vcount = 10'(v);
    LEDs   = leds;
    @(posedge clk);
    #1;
    check(tag, rgb_out(), model(b, h, v, leds));
  endtask

  // Random h biased toward column boundaries so edges get real coverage.
  function automatic int pick_h();
    int starts [6] = '{664, 584, 504, 384, 304, 224};
    int s;
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 1023));
    s = starts[$urandom_range(0, 5)];
    return s + int'($urandom_range(0, 41)) - 1;
  endfunction

  function automatic int pick_v();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1023));
      1:       return 228 + int'($urandom_range(0, 2));
      2:       return 258 + int'($urandom_range(0, 2));
      default: return int'($urandom_range(229, 259));
    endcase
  endfunction

  initial begin
    rst_n  = 1'b0;
    bright = 1'b1;
    hcount = 10'd333;
    vcount = 10'd256;
    LEDs   = 6'b111111;

    // Held in reset with inputs that would otherwise light a pixel
    #1;
    check("reset_initial", rgb_out(), 24'h000000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", rgb_out(), 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_first_edge", rgb_out(), 24'h00FF00);

    // Blanking forces black
    apply("blank_h155", 1'b0, 155, 256, 6'b011000);
    apply("blank_h256", 1'b0, 256, 256, 6'b011000);
    apply("blank_h333", 1'b0, 333, 256, 6'b011000);
    apply("blank_h0",   1'b0, 0,   256, 6'b011000);
    check("blank_h0_const", rgb_out(), 24'h000000);

    // Visible region: background, L5 off, L4 on
    apply("bg_h0",   1'b1, 0,   256, 6'b011000);
    check("bg_h0_const", rgb_out(), 24'h000080);
    apply("l5_off",  1'b1, 256, 256, 6'b011000);
    check("l5_off_const", rgb_out(), 24'h404040);
    apply("l4_on",   1'b1, 333, 256, 6'b011000);
    check("l4_on_const", rgb_out(), 24'h00FF00);

    // Boundaries
    apply("h223", 1'b1, 223, 256, 6'b111111);
    check("h223_const", rgb_out(), 24'h000080);
    apply("h224", 1'b1, 224, 256, 6'b111111);
    apply("h263", 1'b1, 263, 256, 6'b111111);
    apply("h264", 1'b1, 264, 256, 6'b111111);
    check("h264_const", rgb_out(), 24'h000080);
    apply("v260", 1'b1, 333, 260, 6'b111111);
    check("v260_const", rgb_out(), 24'h000080);
    apply("v259", 1'b1, 333, 259, 6'b111111);
    apply("v229", 1'b1, 333, 229, 6'b111111);
    apply("v228", 1'b1, 333, 228, 6'b111111);
    apply("h703", 1'b1, 703, 240, 6'b111111);
    apply("h704", 1'b1, 704, 240, 6'b111111);
    apply("max",  1'b1, 1023, 1023, 6'b111111);
    check("max_const", rgb_out(), 24'h000080);

    // LED change takes effect exactly one edge later
    apply("lat_on", 1'b1, 333, 256, 6'b111111);
    @(negedge clk);
    LEDs = 6'b101111;
    #1;
    check("lat_before_edge", rgb_out(), 24'h00FF00);
    @(posedge clk);
    #1;
    check("lat_after_edge", rgb_out(), 24'h404040);

    // Mid-cycle asynchronous reset
    apply("rst_pre_on", 1'b1, 333, 256, 6'b111111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", rgb_out(), 24'h000000);
    @(posedge clk);
    #1;
    check("async_reset_hold", rgb_out(), 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_reset_release", rgb_out(), 24'h00FF00);

    // Light edge pixels (white when the border build option is on)
    apply("border_h304", 1'b1, 304, 240, 6'b000000);
`ifdef VGA_TIMER_LIGHT_BORDER_EN
    check("border_h304_const", rgb_out(), 24'hFFFFFF);
`else
    check("border_h304_const", rgb_out(), 24'h404040);
`endif
    apply("border_h305", 1'b1, 305, 240, 6'b000000);
    check("border_h305_const", rgb_out(), 24'h404040);
    apply("border_blank", 1'b0, 304, 240, 6'b000000);

    // Randomized pixels
    for (int i = 0; i < 600; i++) begin
      apply("random", ($urandom_range(0, 7) != 0), pick_h(), pick_v(), 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
